// File: rtl/rf_sequencer_if.sv
// Command handshake, register-file port bundle and status outputs of rf_sequencer.
// The master modport is the sequencer side; slave is the instruction source / register-file side.
interface rf_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [17:0]      cmd_instr;
    logic [4:0]       rf_read1_addr;
    logic [4:0]       rf_read2_addr;
    logic             rf_read1_valid;
    logic             rf_read2_valid;
    logic [7:0]       rf_read1_value;
    logic [7:0]       rf_read2_value;
    logic [4:0]       rf_write_addr;
    logic [7:0]       rf_write_value;
    logic             rf_write_valid;
    logic             done;
    logic [4:0]       done_rd;
    logic [7:0]       done_result;
    logic             busy;
    logic [CNT_W-1:0] retired_count;

    modport master (
        input  cmd_valid, cmd_instr, rf_read1_value, rf_read2_value,
        output cmd_ready, rf_read1_addr, rf_read2_addr, rf_read1_valid, rf_read2_valid,
        output rf_write_addr, rf_write_value, rf_write_valid,
        output done, done_rd, done_result, busy, retired_count
    );

    modport slave (
        output cmd_valid, cmd_instr, rf_read1_value, rf_read2_value,
        input  cmd_ready, rf_read1_addr, rf_read2_addr, rf_read1_valid, rf_read2_valid,
        input  rf_write_addr, rf_write_value, rf_write_valid,
        input  done, done_rd, done_result, busy, retired_count
    );
endinterface

// File: rtl/rf_sequencer.sv
// Single-issue IDLE->READ->EXEC->WRITE controller for a 32x8 register file.
// All outputs are decoded from the state register and the latched instruction/result.
module rf_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    rf_sequencer_if.master  bus
);
    typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WRITE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [17:0]      r_instr;
    logic [7:0]       r_result;
    logic [CNT_W-1:0] r_retired;

    logic [2:0] w_op;
    logic [4:0] w_rd;
    logic [4:0] w_rs1;
    logic [4:0] w_rs2;
    logic [7:0] w_imm;

    assign w_op  = r_instr[17:15];
    assign w_rd  = r_instr[14:10];
    assign w_rs1 = r_instr[9:5];
    assign w_rs2 = r_instr[4:0];
    assign w_imm = r_instr[7:0];

    function automatic logic [7:0] f_alu(input logic [2:0] op, input logic [7:0] a,
                                         input logic [7:0] b, input logic [7:0] imm);
        logic [7:0] res;
        case (op)
            3'd0:    res = a + b;
            3'd1:    res = a - b;
            3'd2:    res = a & b;
            3'd3:    res = a | b;
            3'd4:    res = a ^ b;
            3'd5:    res = imm;
            3'd6:    res = a;
            default: res = 8'd0;
        endcase
        return res;
    endfunction

    logic       w_cmd_ready;
    logic       w_rd1_valid;
    logic       w_rd2_valid;
    logic [4:0] w_rd1_addr;
    logic [4:0] w_rd2_addr;
    logic       w_wr_valid;
    logic [4:0] w_wr_addr;
    logic [7:0] w_wr_value;
    logic       w_done;
    logic [4:0] w_done_rd;
    logic [7:0] w_done_result;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_WRITE)
                r_retired <= r_retired + 1'b1;
        end
    end

    // Datapath registers carry no reset: every output using them is gated by state.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && bus.cmd_valid)
            r_instr <= bus.cmd_instr;
        if (r_state == S_EXEC)
            r_result <= f_alu(w_op, bus.rf_read1_value, bus.rf_read2_value, w_imm);
    end

    always_comb begin
        w_next        = r_state;
        w_cmd_ready   = 1'b0;
        w_rd1_valid   = 1'b0;
        w_rd2_valid   = 1'b0;
        w_rd1_addr    = 5'd0;
        w_rd2_addr    = 5'd0;
        w_wr_valid    = 1'b0;
        w_wr_addr     = 5'd0;
        w_wr_value    = 8'd0;
        w_done        = 1'b0;
        w_done_rd     = 5'd0;
        w_done_result = 8'd0;
        case (r_state)
            S_IDLE: begin
                w_cmd_ready = 1'b1;
                if (bus.cmd_valid)
                    w_next = S_READ;
            end
            S_READ: begin
                w_next      = S_EXEC;
                w_rd1_valid = (w_op <= 3'd4) || (w_op == 3'd6);
                w_rd2_valid = (w_op <= 3'd4);
                w_rd1_addr  = w_rs1;
                w_rd2_addr  = w_rs2;
            end
            S_EXEC: w_next = S_WRITE;
            S_WRITE: begin
                w_next        = S_IDLE;
                // Reset arriving during WRITE must suppress the commit on that same edge.
                w_wr_valid    = (w_op != 3'd7) && rst_n;
                w_wr_addr     = w_rd;
                w_wr_value    = r_result;
                w_done        = rst_n;
                w_done_rd     = w_rd;
                w_done_result = r_result;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign bus.cmd_ready      = w_cmd_ready;
    assign bus.rf_read1_valid = w_rd1_valid;
    assign bus.rf_read2_valid = w_rd2_valid;
    assign bus.rf_read1_addr  = w_rd1_addr;
    assign bus.rf_read2_addr  = w_rd2_addr;
    assign bus.rf_write_valid = w_wr_valid;
    assign bus.rf_write_addr  = w_wr_addr;
    assign bus.rf_write_value = w_wr_value;
    assign bus.done           = w_done;
    assign bus.done_rd        = w_done_rd;
    assign bus.done_result    = w_done_result;
    assign bus.busy           = (r_state != S_IDLE);
    assign bus.retired_count  = r_retired;
endmodule

// File: tb/tb_rf_sequencer.sv
// Directed and randomized bench for rf_sequencer with a behavioural register-file model.
module tb_rf_sequencer;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    rf_sequencer_if #(.CNT_W(CNT_W)) bus();
    rf_sequencer #(.CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // Register file environment: registered reads, one write port, plus a seeding port.
    logic [7:0] rf_mem [32];
    logic [7:0] rd1_q = 8'd0;
    logic [7:0] rd2_q = 8'd0;
    logic       seed_en = 1'b0;
    logic [4:0] seed_addr = 5'd0;
    logic [7:0] seed_val = 8'd0;

    always @(posedge clk) begin
        if (seed_en) rf_mem[seed_addr] <= seed_val;
        else if (bus.rf_write_valid) rf_mem[bus.rf_write_addr] <= bus.rf_write_value;
        if (bus.rf_read1_valid) rd1_q <= rf_mem[bus.rf_read1_addr];
        if (bus.rf_read2_valid) rd2_q <= rf_mem[bus.rf_read2_addr];
    end
    assign bus.rf_read1_value = rd1_q;
    assign bus.rf_read2_value = rd2_q;

    int ref_regs [32];
    int exp_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_res(input int op, input int a, input int b, input int imm);
        case (op)
            0: return (a + b) % 256;
            1: return (a - b + 256) % 256;
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return imm;
            6: return a;
            default: return 0;
        endcase
    endfunction

    function automatic logic [17:0] mk(input int op, input int rd, input int rs1, input int rs2);
        return {3'(op), 5'(rd), 5'(rs1), 5'(rs2)};
    endfunction

    function automatic logic [17:0] mk_li(input int rd, input int imm);
        return {3'd5, 5'(rd), 2'b00, 8'(imm)};
    endfunction

    task automatic wait_ready();
        int guard = 0;
        while (!bus.cmd_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("ready_wait", 32'(bus.cmd_ready), 32'd1);
    endtask

    task automatic run_op(input logic [17:0] instr);
        int op, rd, rs1, rs2, imm, exp_res;
        op  = int'(instr[17:15]);
        rd  = int'(instr[14:10]);
        rs1 = int'(instr[9:5]);
        rs2 = int'(instr[4:0]);
        imm = int'(instr[7:0]);
        exp_res = ref_res(op, ref_regs[rs1], ref_regs[rs2], imm);
        @(negedge clk);
        wait_ready();
        bus.cmd_valid = 1'b1;
        bus.cmd_instr = instr;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_instr = 18'($urandom);
        // READ
        chk("read_busy", 32'(bus.busy), 32'd1);
        chk("read_ready", 32'(bus.cmd_ready), 32'd0);
        chk("read_rd1v", 32'(bus.rf_read1_valid), 32'((op <= 4) || (op == 6)));
        chk("read_rd2v", 32'(bus.rf_read2_valid), 32'(op <= 4));
        chk("read_rd1a", 32'(bus.rf_read1_addr), 32'(rs1));
        chk("read_rd2a", 32'(bus.rf_read2_addr), 32'(rs2));
        chk("read_wrv", 32'(bus.rf_write_valid), 32'd0);
        chk("read_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        // EXEC
        chk("exec_rdv", 32'({bus.rf_read1_valid, bus.rf_read2_valid}), 32'd0);
        chk("exec_wrv", 32'(bus.rf_write_valid), 32'd0);
        chk("exec_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        // WRITE
        chk("wr_done", 32'(bus.done), 32'd1);
        chk("wr_done_rd", 32'(bus.done_rd), 32'(rd));
        chk("wr_done_result", 32'(bus.done_result), 32'(exp_res));
        chk("wr_valid", 32'(bus.rf_write_valid), 32'(op != 7));
        chk("wr_rdv", 32'({bus.rf_read1_valid, bus.rf_read2_valid}), 32'd0);
        if (op != 7) begin
            chk("wr_addr", 32'(bus.rf_write_addr), 32'(rd));
            chk("wr_value", 32'(bus.rf_write_value), 32'(exp_res));
            ref_regs[rd] = exp_res;
        end
        chk("wr_count", 32'(bus.retired_count), 32'(exp_cnt));
        exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
        @(negedge clk);
        chk("idle_ready", 32'(bus.cmd_ready), 32'd1);
        chk("idle_busy", 32'(bus.busy), 32'd0);
        chk("idle_done", 32'(bus.done), 32'd0);
        chk("idle_count", 32'(bus.retired_count), 32'(exp_cnt));
    endtask

    initial begin
        logic [17:0] qi [3];
        int idx, nd, last_rdy, rdy_cnt;
        bit pending;

        bus.cmd_valid = 1'b0;
        bus.cmd_instr = 18'd0;
        rst_n = 1'b0;
        for (int i = 0; i < 32; i++) begin
            seed_en   = 1'b1;
            seed_addr = 5'(i);
            seed_val  = 8'($urandom);
            ref_regs[i] = int'(seed_val);
            @(negedge clk);
        end
        seed_en = 1'b0;
        rst_n = 1'b1;

        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("rst_rdv", 32'({bus.rf_read1_valid, bus.rf_read2_valid}), 32'd0);
            chk("rst_addr", 32'({bus.rf_read1_addr, bus.rf_read2_addr, bus.rf_write_addr}), 32'd0);
            chk("rst_wr", 32'({bus.rf_write_valid, bus.rf_write_value}), 32'd0);
            chk("rst_done", 32'({bus.done, bus.done_rd, bus.done_result}), 32'd0);
            chk("rst_busy", 32'(bus.busy), 32'd0);
            chk("rst_ready", 32'(bus.cmd_ready), 32'd1);
            chk("rst_count", 32'(bus.retired_count), 32'd0);
        end

        run_op(mk_li(1, 8'h0F));
        run_op(mk_li(2, 8'hF3));
        run_op(mk(0, 3, 1, 2));
        chk("add_wrap_r3", 32'(rf_mem[3]), 32'h02);
        chk("count_3", 32'(bus.retired_count), 32'd3);
        run_op(mk(1, 4, 1, 2));
        chk("sub_r4", 32'(rf_mem[4]), 32'h1C);
        run_op(mk(1, 5, 2, 2));
        chk("sub_r5", 32'(rf_mem[5]), 32'h00);
        run_op(mk(6, 6, 2, 0));
        chk("mov_r6", 32'(rf_mem[6]), 32'hF3);
        run_op(mk(7, 9, 3, 4));
        run_op(mk_li(0, 8'hA5));
        chk("li_r0", 32'(rf_mem[0]), 32'hA5);

        // Held cmd_valid with three queued LIs: one accept every 4 cycles, in order.
        for (int i = 0; i < 3; i++) qi[i] = mk_li(10 + i, int'($urandom_range(0, 255)));
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_instr = qi[0];
        idx = 0; nd = 0; last_rdy = -1; rdy_cnt = 0; pending = 1'b0;
        for (int c = 0; c < 16; c++) begin
            if (pending) begin
                idx++;
                if (idx < 3) bus.cmd_instr = qi[idx];
                else bus.cmd_valid = 1'b0;
                pending = 1'b0;
            end
            if (bus.done) begin
                chk("q_done_rd", 32'(bus.done_rd), 32'(qi[nd][14:10]));
                chk("q_done_result", 32'(bus.done_result), 32'(qi[nd][7:0]));
                ref_regs[int'(qi[nd][14:10])] = int'(qi[nd][7:0]);
                exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
                nd++;
            end
            if (bus.cmd_ready && bus.cmd_valid) begin
                if (last_rdy >= 0) chk("q_ready_gap", 32'(c - last_rdy), 32'd4);
                last_rdy = c;
                rdy_cnt++;
                pending = 1'b1;
            end
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
        chk("q_accepts", 32'(rdy_cnt), 32'd3);
        chk("q_dones", 32'(nd), 32'd3);
        chk("q_count", 32'(bus.retired_count), 32'(exp_cnt));

        // Reset during EXEC of ADD r7,r1,r2: op dropped, r7 keeps its prior value.
        wait_ready();
        bus.cmd_valid = 1'b1;
        bus.cmd_instr = mk(0, 7, 1, 2);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rstx_done", 32'(bus.done), 32'd0);
        chk("rstx_wrv", 32'(bus.rf_write_valid), 32'd0);
        chk("rstx_busy", 32'(bus.busy), 32'd0);
        chk("rstx_count", 32'(bus.retired_count), 32'd0);
        rst_n = 1'b1;
        exp_cnt = 0;
        @(negedge clk);
        chk("rstx_r7", 32'(rf_mem[7]), 32'(ref_regs[7]));
        chk("rstx_idle_done", 32'(bus.done), 32'd0);
        run_op(mk(6, 8, 7, 0));

        // Reset asserted during WRITE of LI r9: no commit, no done.
        wait_ready();
        bus.cmd_valid = 1'b1;
        bus.cmd_instr = mk_li(9, int'(8'(ref_regs[9] ^ 8'hFF)));
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rstw_done", 32'(bus.done), 32'd0);
        chk("rstw_wrv", 32'(bus.rf_write_valid), 32'd0);
        @(negedge clk);
        chk("rstw_r9", 32'(rf_mem[9]), 32'(ref_regs[9]));
        chk("rstw_count", 32'(bus.retired_count), 32'd0);
        chk("rstw_busy", 32'(bus.busy), 32'd0);
        rst_n = 1'b1;
        exp_cnt = 0;

        // Random operations; enough of them to wrap the narrow retired counter.
        for (int i = 0; i < 24; i++)
            run_op(18'($urandom));

        for (int i = 0; i < 32; i++)
            chk("final_rf", 32'(rf_mem[i]), 32'(ref_regs[i]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
